fp_to_int_cvt: RTL and testbench
================================

// Module: fp_to_int_cvt
// PURPOSE
//  FP32 -> INT32/UINT32 converter (FCVT.W.S / FCVT.WU.S), the reverse of the int->float normalize path.
//  Unpacks, right-aligns the significand by the unbiased exponent, rounds per rm, saturates and
//  raises fflags. Sits in the FPU execute slot. Two-stage pipeline with valid/ready back-pressure.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; only 32 is supported.
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  in_valid     in   1   request valid
//  in_ready     out  1   converter can accept a request this cycle
//  fp_in        in   32  IEEE-754 binary32 operand
//  is_unsigned  in   1   1: FCVT.WU.S, 0: FCVT.W.S
//  rm           in   3   rounding mode, RISC-V encoding, already resolved from frm
//  out_valid    out  1   result valid
//  out_ready    in   1   consumer accepts the result
//  int_out      out  32  integer result
//  fflags_out   out  5   {NV,DZ,OF,UF,NX}; only NV and NX are ever set
// BEHAVIOUR
//  Reset: out_valid=0, int_out=0, fflags_out=0, both stage valids=0. in_ready=1 after reset.
//  Handshake: transfer on valid&ready. S2 advances when !s2_valid | out_ready. S1 advances when
//   !s1_valid | S2 advances. in_ready = S1 advances. Full throughput 1/cycle; latency 2 cycles.
//  Stall: while out_valid & !out_ready, int_out/fflags_out hold stable. No bubbles are inserted.
//  Reset asserted mid-operation drops all in-flight requests immediately, with no output.
//  S1 (align): sign s, e = exp-127, sig = {1,frac} (exp==0: sig = {0,frac}).
//   e<0 -> mag=0, round bit = (e==-1 & exp!=0), sticky = frac!=0 | e<-1 (zero exp, zero frac: exact 0).
//   0<=e<=23 -> mag = sig>>(23-e); round bit and sticky from the shifted-out bits.
//   24<=e<=31 -> mag = sig<<(e-23), exact. e>=32, or exp==255 -> overflow class.
//  S2 (round/saturate): inc per rm. RNE: r&(st|lsb). RTZ: 0. RDN: s&(r|st). RUP: !s&(r|st).
//   RMM: r. rm 5..7 are treated as RTZ with no extra flag. mag33 = mag+inc, 33-bit.
//  Limits: signed +2^31-1 / -2^31; unsigned 2^32-1 / 0.
//  Saturation (NV=1, NX=0):
//   - NaN -> 0x7FFFFFFF signed, 0xFFFFFFFF unsigned.
//   - +inf or positive overflow -> 0x7FFFFFFF / 0xFFFFFFFF.
//   - -inf or negative overflow -> 0x80000000 / 0x00000000.
//   - Unsigned negative with mag33 != 0 -> 0x00000000.
//   - Signed: positive mag33 > 2^31-1, or negative mag33 > 2^31, overflows.
//  Otherwise: result = s ? -mag33 : mag33 (signed) or mag33 (unsigned); NX = r|st.
//   Unsigned negative that rounds to 0 gives 0 with NX only.
//  -0.0 -> 0, no flags. Denormals behave as nonzero magnitude < 1.
// STRUCTURE
//  fpu_pkg: rm_e enum (RNE=0,RTZ=1,RDN=2,RUP=3,RMM=4), FFLAG_NV/FFLAG_NX bit indices,
//   FP32 field widths, BIAS=127, INT32_MAX/INT32_MIN/UINT32_MAX constants.
//  Sub-module fcvt_align_shifter: combinational right/left barrel shift producing
//   {mag[31:0], round, sticky}, instantiated in S1. Rounding/saturation stays inline in S2.
// TESTING
//  1 0x3FC00000 (1.5), W, RNE -> 0x00000002, NX; same with RTZ -> 0x00000001, NX.
//  2 0x40200000 (2.5) RNE -> 2, NX; 0xBFC00000 (-1.5) RDN -> 0xFFFFFFFE, NX; RMM on 2.5 -> 3.
//  3 0x4F000000 (2^31): W -> 0x7FFFFFFF, NV; WU -> 0x80000000, no flags;
//    0xCF000000 W -> 0x80000000, no flags.
//  4 0x7FC00000 (NaN) W -> 0x7FFFFFFF, NV; 0xFF800000 WU -> 0, NV;
//    0xBE99999A (-0.3) WU RTZ -> 0, NX only.
//  5 Back-to-back 8 requests with out_ready toggling 1,0,0,1...: results in order,
//    none lost or duplicated, outputs stable while stalled, in_ready=0 only when both stages full.
//  6 rst_n pulled low with both stages valid -> out_valid=0 asynchronously;
//    after release in_ready=1 and the next request completes in 2 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: rounding-mode encoding, fflags bit positions,
// binary32 field widths and the integer saturation limits.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_e;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_NX = 0;

    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;
    localparam int FP32_SIG_W  = FP32_FRAC_W + 1;

    localparam logic [FP32_EXP_W-1:0] BIAS = 8'd127;

    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        sign;
        logic        uns;
        logic        nan;
        logic        ovf;
        rm_e         rm;
        logic [31:0] mag;
        logic        rnd;
        logic        stk;
    } s1_t;

endpackage

// File: rtl/fcvt_align_shifter.sv
// Aligns a 24-bit significand for an unbiased exponent 0..31 into a 32-bit
// integer magnitude plus round and sticky bits.
module fcvt_align_shifter
    import fpu_pkg::*;
(
    input  logic [FP32_SIG_W-1:0] sig,
    input  logic [4:0]            exp_unb,
    output logic [31:0]           mag,
    output logic                  rnd,
    output logic                  stk
);

    logic [5:0]  sh_amt;
    logic [63:0] fixed;

    // Binary point sits between bits 32 and 31, so sig lands at 2^(exp_unb-23).
    assign sh_amt = {1'b0, exp_unb} + 6'd9;
    assign fixed  = {40'd0, sig} << sh_amt;

    assign mag = fixed[63:32];
    assign rnd = fixed[31];
    assign stk = |fixed[30:0];

endmodule

// File: rtl/fp_to_int_cvt.sv
// FP32 -> INT32/UINT32 converter (FCVT.W.S / FCVT.WU.S): stage 1 aligns the
// significand, stage 2 rounds and saturates. Valid/ready pipeline, 2-cycle latency.
module fp_to_int_cvt
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] fp_in,
    input  logic                  is_unsigned,
    input  logic [2:0]            rm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] int_out,
    output logic [4:0]            fflags_out
);

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   s1_adv;
    logic                   s2_adv;
    s1_t                    s1_d;
    s1_t                    s1_q;

    logic [FP32_EXP_W-1:0]  exp_f;
    logic [FP32_FRAC_W-1:0] frac_f;
    logic [FP32_SIG_W-1:0]  sig_f;
    logic [4:0]             exp_unb;
    logic [31:0]            sh_mag;
    logic                   sh_rnd;
    logic                   sh_stk;

    logic                   inc;
    logic [32:0]            mag33;
    logic [31:0]            res;
    logic [4:0]             flags;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    assign exp_f  = fp_in[30:23];
    assign frac_f = fp_in[22:0];
    assign sig_f  = {exp_f != 8'd0, frac_f};
    // exp - 127 modulo 32 equals exp[4:0] + 1; only used when 127 <= exp <= 158.
    assign exp_unb = exp_f[4:0] + 5'd1;

    fcvt_align_shifter u_align (
        .sig     (sig_f),
        .exp_unb (exp_unb),
        .mag     (sh_mag),
        .rnd     (sh_rnd),
        .stk     (sh_stk)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.sign = fp_in[31];
        s1_d.uns  = is_unsigned;
        s1_d.rm   = rm_e'(rm);
        s1_d.nan  = (exp_f == 8'hFF) && (frac_f != '0);
        s1_d.ovf  = exp_f >= (BIAS + 8'd32);
        if (exp_f < BIAS) begin
            s1_d.mag = '0;
            s1_d.rnd = exp_f == (BIAS - 8'd1);
            s1_d.stk = (frac_f != '0) || ((exp_f != 8'd0) && (exp_f < (BIAS - 8'd1)));
        end else if (!s1_d.ovf) begin
            s1_d.mag = sh_mag;
            s1_d.rnd = sh_rnd;
            s1_d.stk = sh_stk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_comb begin
        inc = 1'b0;
        case (s1_q.rm)
            RNE:     inc = s1_q.rnd && (s1_q.stk || s1_q.mag[0]);
            RDN:     inc = s1_q.sign && (s1_q.rnd || s1_q.stk);
            RUP:     inc = !s1_q.sign && (s1_q.rnd || s1_q.stk);
            RMM:     inc = s1_q.rnd;
            default: inc = 1'b0;
        endcase
        mag33 = {1'b0, s1_q.mag} + {32'd0, inc};

        res   = '0;
        flags = '0;
        if (s1_q.nan) begin
            flags[FFLAG_NV] = 1'b1;
            res             = s1_q.uns ? UINT32_MAX : INT32_MAX;
        end else if (s1_q.ovf) begin
            flags[FFLAG_NV] = 1'b1;
            if (s1_q.sign) begin
                res = s1_q.uns ? 32'd0 : INT32_MIN;
            end else begin
                res = s1_q.uns ? UINT32_MAX : INT32_MAX;
            end
        end else if (s1_q.uns) begin
            if (s1_q.sign && (mag33 != '0)) begin
                flags[FFLAG_NV] = 1'b1;
                res             = 32'd0;
            end else if (mag33[32]) begin
                flags[FFLAG_NV] = 1'b1;
                res             = UINT32_MAX;
            end else begin
                flags[FFLAG_NX] = s1_q.rnd || s1_q.stk;
                res             = mag33[31:0];
            end
        end else begin
            if (!s1_q.sign && (mag33 > {1'b0, INT32_MAX})) begin
                flags[FFLAG_NV] = 1'b1;
                res             = INT32_MAX;
            end else if (s1_q.sign && (mag33 > {1'b0, INT32_MIN})) begin
                flags[FFLAG_NV] = 1'b1;
                res             = INT32_MIN;
            end else begin
                flags[FFLAG_NX] = s1_q.rnd || s1_q.stk;
                res             = s1_q.sign ? (~mag33[31:0] + 32'd1) : mag33[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            int_out    <= '0;
            fflags_out <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                int_out    <= res;
                fflags_out <= flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_to_int_cvt.sv
// Directed bench for fp_to_int_cvt: single conversions against hand-computed
// results, back-pressured streaming, and mid-flight asynchronous reset.
module tb_fp_to_int_cvt;

    typedef struct packed {
        logic [31:0] fp;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] exp_int;
        logic [4:0]  exp_flags;
    } vec_t;

    localparam int NV = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_in = '0;
    logic        is_unsigned = 1'b0;
    logic [2:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] int_out;
    logic [4:0]  fflags_out;

    int n_checks = 0;
    int n_errs   = 0;
    vec_t vecs [NV];

    fp_to_int_cvt #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fp_in       (fp_in),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .int_out     (int_out),
        .fflags_out  (fflags_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_vec(input int idx);
        fp_in       = vecs[idx].fp;
        is_unsigned = vecs[idx].uns;
        rm          = vecs[idx].rm;
    endtask

    task automatic send_chk(input int idx);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_vec(idx);
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("v%0d_lat", idx), n, 2);
        check_eq($sformatf("v%0d_int", idx), int_out, vecs[idx].exp_int);
        check_eq($sformatf("v%0d_flags", idx), {27'd0, fflags_out}, {27'd0, vecs[idx].exp_flags});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        logic stalled;
        logic [31:0] hold_i;
        logic [4:0]  hold_f;

        //          fp            uns   rm    int            flags
        vecs = '{
            '{32'h3FC00000, 1'b0, 3'd0, 32'h00000002, 5'h01},
            '{32'h3FC00000, 1'b0, 3'd1, 32'h00000001, 5'h01},
            '{32'h40200000, 1'b0, 3'd0, 32'h00000002, 5'h01},
            '{32'hBFC00000, 1'b0, 3'd2, 32'hFFFFFFFE, 5'h01},
            '{32'h40200000, 1'b0, 3'd4, 32'h00000003, 5'h01},
            '{32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10},
            '{32'h4F000000, 1'b1, 3'd0, 32'h80000000, 5'h00},
            '{32'hCF000000, 1'b0, 3'd0, 32'h80000000, 5'h00},
            '{32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10},
            '{32'hFF800000, 1'b1, 3'd0, 32'h00000000, 5'h10},
            '{32'hBE99999A, 1'b1, 3'd1, 32'h00000000, 5'h01},
            '{32'h80000000, 1'b0, 3'd0, 32'h00000000, 5'h00},
            '{32'h3F000000, 1'b0, 3'd0, 32'h00000000, 5'h01},
            '{32'h3F000000, 1'b0, 3'd3, 32'h00000001, 5'h01},
            '{32'hBF000000, 1'b0, 3'd3, 32'h00000000, 5'h01},
            '{32'h4B000000, 1'b0, 3'd0, 32'h00800000, 5'h00},
            '{32'h4F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 5'h10},
            '{32'h4F7FFFFF, 1'b1, 3'd1, 32'hFFFFFF00, 5'h00},
            '{32'h00000001, 1'b0, 3'd3, 32'h00000001, 5'h01},
            '{32'h3FC00000, 1'b0, 3'd5, 32'h00000001, 5'h01},
            '{32'hBF800000, 1'b1, 3'd0, 32'h00000000, 5'h10},
            '{32'hCF000001, 1'b0, 3'd0, 32'h80000000, 5'h10},
            '{32'h7F800000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10},
            '{32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 5'h10},
            '{32'h3F7FFFFF, 1'b0, 3'd0, 32'h00000001, 5'h01},
            '{32'hBF400000, 1'b0, 3'd0, 32'hFFFFFFFF, 5'h01},
            '{32'hC0200000, 1'b0, 3'd4, 32'hFFFFFFFD, 5'h01},
            '{32'h3FC00000, 1'b1, 3'd7, 32'h00000001, 5'h01},
            '{32'hBF000000, 1'b1, 3'd0, 32'h00000000, 5'h01},
            '{32'hBF400000, 1'b1, 3'd0, 32'h00000000, 5'h10},
            '{32'h407FFFFF, 1'b0, 3'd2, 32'h00000003, 5'h01}
        };

        // reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_int_out", int_out, 32'd0);
        check_eq("rst_fflags", {27'd0, fflags_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // directed single conversions
        for (int i = 0; i < NV; i++) begin
            send_chk(i);
        end

        // streaming with back-pressure: out_ready pattern 1,0,0,1,0,0,...
        sent    = 0;
        recv    = 0;
        stalled = 1'b0;
        hold_i  = '0;
        hold_f  = '0;
        for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
                check_eq("stall_int", int_out, hold_i);
                check_eq("stall_flags", {27'd0, fflags_out}, {27'd0, hold_f});
            end
            out_ready = (cyc % 3 == 0);
            if (sent < 8) begin
                in_valid = 1'b1;
                drive_vec(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check_eq("stream_in_ready", {31'd0, in_ready},
                     {31'd0, !((sent - recv) == 2 && !out_ready)});
            if (out_valid && out_ready) begin
                check_eq($sformatf("stream%0d_int", recv), int_out, vecs[recv].exp_int);
                check_eq($sformatf("stream%0d_flags", recv), {27'd0, fflags_out},
                         {27'd0, vecs[recv].exp_flags});
                recv++;
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                hold_i = int_out;
                hold_f = fflags_out;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
        end
        check_eq("stream_count", recv, 8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stream_no_dup", {31'd0, out_valid}, 32'd0);
        end

        // fill both stages, then reset asynchronously between clock edges
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_vec(5);
        @(negedge clk);
        drive_vec(6);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("full_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("async_int_out", int_out, 32'd0);
        check_eq("async_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_out", {31'd0, out_valid}, 32'd0);
        end
        send_chk(3);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
